bcd_scan_counter: RTL and testbench
===================================

BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of BCD digits and display positions (1..8).
REQ-002 SHALL have parameter TICK_DIV, default 50000000, clk cycles per count tick (>=2).
REQ-003 SHALL have parameter REFRESH_DIV, default 100000, clk cycles each display digit stays lit (>=2).
REQ-004 SHALL have port: clk  in  1  system clock; all logic in this single domain.
REQ-005 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port: enable  in  1  prescaler and counting run while 1.
REQ-007 SHALL have port: up_down  in  1  1 = count up, 0 = count down.
REQ-008 SHALL have port: load  in  1  synchronous load strobe.
REQ-009 SHALL have port: load_value  in  4*DIGITS  BCD value to load; digit i at bits [4i+3:4i].
REQ-010 SHALL have port: bcd  out  4*DIGITS  current count, registered.
REQ-011 SHALL have port: wrap  out  1  one-cycle pulse on counter roll-over.
REQ-012 SHALL have port: anodes  out  DIGITS  active-low one-hot digit select, registered.
REQ-013 SHALL have port: segments  out  8  active-low; [6:0] = g..a, [7] = dp; registered.

Function
REQ-014 SHALL generate a one-cycle tick from prescaler 0..TICK_DIV-1; tick asserts when prescaler = TICK_DIV-1, then prescaler wraps to 0.
REQ-015 SHALL hold the prescaler while enable=0; SHALL NOT derive any clock from logic (tick is an enable only).
REQ-016 SHALL, on tick with up_down=1, increment bcd with decimal carry per digit (9 -> 0, carry to next).
REQ-017 SHALL, on tick with up_down=0, decrement bcd with decimal borrow per digit (0 -> 9, borrow to next).
REQ-018 SHALL wrap all-9s -> all-0s (up) and all-0s -> all-9s (down), asserting wrap the same cycle bcd takes the wrapped value.
REQ-019 SHALL update bcd one clk after the tick cycle.
REQ-020 SHALL, on load=1, set bcd to load_value, clear prescaler, suppress wrap; load takes priority over a coincident tick and works regardless of enable.
REQ-021 SHALL clamp any load_value digit above 9 to 9.
REQ-022 SHALL scan digits with a refresh counter 0..REFRESH_DIV-1 and index 0..DIGITS-1, advancing index (wrap to 0) when counter = REFRESH_DIV-1; scanning is independent of enable.
REQ-023 SHALL drive anodes[index]=0, all others 1; segments = decoded bcd digit[index], dp=1; both registered one clk after index changes.
REQ-024 SHALL decode 0..9 active-low: 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90 (hex, dp included).

Reset
REQ-025 SHALL asynchronously on reset=1 clear bcd, prescaler, refresh counter, index and wrap to 0.
REQ-026 SHALL reset anodes to all 1s except bit 0 = 0, and segments to C0.
REQ-027 SHALL resume counting from 0 with a full TICK_DIV period after reset deasserts, including mid-count reset.

Configuration
REQ-028 SHALL support macro BCD_SCAN_LEADING_ZERO_BLANK_EN.
REQ-029 SHALL, with the macro defined, drive segments FF for any digit that is zero and more significant than the highest nonzero digit; digit 0 is never blanked (value 0 shows C0 on digit 0 only).
REQ-030 SHALL, without the macro, display every digit including leading zeros.

Structure
REQ-031 SHALL place the 7-seg code constants, segment blank value (FF) and the bcd digit type in shared package bcd_disp_pkg.
REQ-032 SHALL implement the 0..9 decode in sub-module seg7_bcd_decode (4-bit in, 8-bit active-low out, combinational), instantiated once on the muxed digit.

Verification (DIGITS=4, TICK_DIV=4, REFRESH_DIV=2 unless stated)
REQ-033 SHALL cover: reset, enable=1 up, 12 clk -> bcd 0003, no wrap; anodes cycle E,D,B,7 every 2 clk.
REQ-034 SHALL cover: load 9998, up, 2 ticks -> bcd 9999 then 0000 with wrap high exactly 1 cycle.
REQ-035 SHALL cover: load 0001, up_down=0, 2 ticks -> 0000 then 9999 with wrap pulse; load_value F0A3 -> bcd 9093.
REQ-036 SHALL cover: load asserted on tick cycle with load_value 0042 -> bcd 0042, no increment, no wrap; enable=0 for 20 clk -> bcd unchanged.
REQ-037 SHALL cover: reset asserted mid-count at bcd 0057 -> bcd 0000, anodes E, segments C0 without waiting for clk edge.
REQ-038 SHALL cover: macro defined, bcd 0042 -> digits 3,2 show FF, digit1 99, digit0 A4; bcd 0000 -> only digit0 shows C0.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// Shared seven-segment constants and BCD digit type for the scanned counter display.
package bcd_disp_pkg;

   typedef logic [3:0] bcd_digit_t;

   // Active-low segment codes, bit 7 = dp (kept dark), bits 6:0 = g..a
   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

endpackage

// File: rtl/seg7_bcd_decode.sv
// Combinational BCD digit to active-low seven-segment code; non-BCD inputs go dark.
module seg7_bcd_decode
   import bcd_disp_pkg::*;
(
   input  logic [3:0] digit,
   output logic [7:0] seg_n
);

   always_comb begin
      case (digit)
         4'd0:    seg_n = SEG_0;
         4'd1:    seg_n = SEG_1;
         4'd2:    seg_n = SEG_2;
         4'd3:    seg_n = SEG_3;
         4'd4:    seg_n = SEG_4;
         4'd5:    seg_n = SEG_5;
         4'd6:    seg_n = SEG_6;
         4'd7:    seg_n = SEG_7;
         4'd8:    seg_n = SEG_8;
         4'd9:    seg_n = SEG_9;
         default: seg_n = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/bcd_scan_counter.sv
// Prescaled up/down BCD counter with a multiplexed seven-segment scanner.
// Optional leading-zero blanking: define BCD_SCAN_LEADING_ZERO_BLANK_EN.
module bcd_scan_counter
   import bcd_disp_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int TICK_DIV    = 50000000,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  up_down,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_value,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  wrap,
   output logic [DIGITS-1:0]     anodes,
   output logic [7:0]            segments
);

   localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int REFR_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
   localparam logic [REFR_W-1:0]  REFR_MAX  = REFR_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0]   IDX_MAX   = IDX_W'(DIGITS - 1);
   localparam logic [DIGITS-1:0]  ANODE_RST = ~(DIGITS'(1));

   logic [PRESC_W-1:0]  presc_q, presc_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d;
   logic                wrap_q, wrap_d;
   logic [REFR_W-1:0]   refr_q, refr_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DIGITS-1:0]   anodes_q, anodes_d;
   logic [7:0]          segments_q, segments_d;

   logic                tick;
   logic                roll;
   logic [4*DIGITS-1:0] next_bcd;
   logic [4*DIGITS-1:0] load_clamped;
   bcd_digit_t          cur_digit;
   logic                sel_blank;
   logic [7:0]          dec_seg;

   assign tick = enable && (presc_q == PRESC_MAX);

   // Ripple decimal carry/borrow; roll survives the loop only on full wrap
   always_comb begin
      bcd_digit_t d;
      next_bcd = bcd_q;
      roll     = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         d = bcd_q[4*i +: 4];
         if (roll) begin
            if (up_down) begin
               if (d >= 4'd9) begin
                  next_bcd[4*i +: 4] = 4'd0;
               end else begin
                  next_bcd[4*i +: 4] = d + 4'd1;
                  roll               = 1'b0;
               end
            end else begin
               if (d == 4'd0) begin
                  next_bcd[4*i +: 4] = 4'd9;
               end else begin
                  next_bcd[4*i +: 4] = d - 4'd1;
                  roll               = 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      load_clamped = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         load_clamped[4*i +: 4] = bcd_clamp(load_value[4*i +: 4]);
      end
   end

   always_comb begin
      presc_d = presc_q;
      bcd_d   = bcd_q;
      wrap_d  = 1'b0;
      if (load) begin
         bcd_d   = load_clamped;
         presc_d = '0;
      end else if (tick) begin
         bcd_d   = next_bcd;
         presc_d = '0;
         wrap_d  = roll;
      end else if (enable) begin
         presc_d = presc_q + PRESC_W'(1);
      end
   end

   always_comb begin
      refr_d = refr_q + REFR_W'(1);
      idx_d  = idx_q;
      if (refr_q == REFR_MAX) begin
         refr_d = '0;
         idx_d  = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
      end
   end

`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0] lead_zero;

   // lead_zero[i]: digit i and everything above it are zero; digit 0 always shown
   always_comb begin
      lead_zero             = '0;
      lead_zero[DIGITS-1]   = (bcd_q[4*(DIGITS-1) +: 4] == 4'd0);
      for (int unsigned k = 2; k <= DIGITS; k++) begin
         lead_zero[DIGITS-k] = lead_zero[DIGITS-k+1] &&
                               (bcd_q[4*(DIGITS-k) +: 4] == 4'd0);
      end
      lead_zero[0] = 1'b0;
   end
`endif

   always_comb begin
      cur_digit = '0;
      sel_blank = 1'b0;
      anodes_d  = '1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_digit   = bcd_q[4*i +: 4];
            anodes_d[i] = 1'b0;
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
            sel_blank   = lead_zero[i];
`endif
         end
      end
   end

   seg7_bcd_decode u_decode (
      .digit (cur_digit),
      .seg_n (dec_seg)
   );

   assign segments_d = sel_blank ? SEG_BLANK : dec_seg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q    <= '0;
         bcd_q      <= '0;
         wrap_q     <= 1'b0;
         refr_q     <= '0;
         idx_q      <= '0;
         anodes_q   <= ANODE_RST;
         segments_q <= SEG_0;
      end else begin
         presc_q    <= presc_d;
         bcd_q      <= bcd_d;
         wrap_q     <= wrap_d;
         refr_q     <= refr_d;
         idx_q      <= idx_d;
         anodes_q   <= anodes_d;
         segments_q <= segments_d;
      end
   end

   assign bcd      = bcd_q;
   assign wrap     = wrap_q;
   assign anodes   = anodes_q;
   assign segments = segments_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed self-checking bench for bcd_scan_counter (DIGITS=4, TICK_DIV=4, REFRESH_DIV=2).
module tb_bcd_scan_counter;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        up_down;
   logic        load;
   logic [15:0] load_value;
   logic [15:0] bcd;
   logic        wrap;
   logic [3:0]  anodes;
   logic [7:0]  segments;

   int n_checks;
   int n_fail;

   bcd_scan_counter #(
      .DIGITS      (4),
      .TICK_DIV    (4),
      .REFRESH_DIV (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .up_down    (up_down),
      .load       (load),
      .load_value (load_value),
      .bcd        (bcd),
      .wrap       (wrap),
      .anodes     (anodes),
      .segments   (segments)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; up_down = 1'b1; load = 1'b0; load_value = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_bcd got=%h exp=0000", bcd); end
      n_checks++;
      if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
      n_checks++;
      if (anodes !== 4'hE) begin n_fail++; $display("FAIL reset_anodes got=%h exp=e", anodes); end
      n_checks++;
      if (segments !== 8'hC0) begin n_fail++; $display("FAIL reset_segments got=%h exp=c0", segments); end
   endtask

   task automatic test_count_up();
      logic [3:0] exp_an;
      int idx;
      reset = 1'b0; enable = 1'b1; up_down = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         idx    = ((k - 1) / 2) % 4;
         exp_an = ~(4'b0001 << idx);
         n_checks++;
         if (anodes !== exp_an) begin n_fail++; $display("FAIL count_up_anodes k=%0d got=%h exp=%h", k, anodes, exp_an); end
         n_checks++;
         if (wrap !== 1'b0) begin n_fail++; $display("FAIL count_up_wrap k=%0d got=%b exp=0", k, wrap); end
         if (k % 4 == 0) begin
            n_checks++;
            if (bcd !== 16'(k / 4)) begin n_fail++; $display("FAIL count_up_bcd k=%0d got=%h exp=%0d", k, bcd, k / 4); end
         end
      end
   endtask

   task automatic test_wrap_up();
      int wraps;
      wraps = 0;
      up_down = 1'b1; enable = 1'b1; load = 1'b1; load_value = 16'h9998;
      @(negedge clk);
      load = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (wrap === 1'b1) wraps++;
         if (k == 4) begin
            n_checks++;
            if (bcd !== 16'h9999 || wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_up_9999 got=%h/%b exp=9999/0", bcd, wrap); end
         end
         if (k == 8) begin
            n_checks++;
            if (bcd !== 16'h0000 || wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_up_0000 got=%h/%b exp=0000/1", bcd, wrap); end
         end
         if (k == 9) begin
            n_checks++;
            if (wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_up_pulse_end got=%b exp=0", wrap); end
         end
      end
      n_checks++;
      if (wraps != 1) begin n_fail++; $display("FAIL wrap_up_count got=%0d exp=1", wraps); end
   endtask

   task automatic test_wrap_down();
      up_down = 1'b0; enable = 1'b1; load = 1'b1; load_value = 16'h0001;
      @(negedge clk);
      load = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (k == 4) begin
            n_checks++;
            if (bcd !== 16'h0000 || wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_down_0000 got=%h/%b exp=0000/0", bcd, wrap); end
         end
         if (k == 8) begin
            n_checks++;
            if (bcd !== 16'h9999 || wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_down_9999 got=%h/%b exp=9999/1", bcd, wrap); end
         end
         if (k == 9) begin
            n_checks++;
            if (wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_down_pulse_end got=%b exp=0", wrap); end
         end
      end
      enable = 1'b0; load = 1'b1; load_value = 16'hF0A3;
      @(negedge clk);
      load = 1'b0;
      n_checks++;
      if (bcd !== 16'h9093) begin n_fail++; $display("FAIL load_clamp got=%h exp=9093", bcd); end
   endtask

   task automatic test_load_priority();
      up_down = 1'b1; enable = 1'b1; load = 1'b1; load_value = 16'h9999;
      @(negedge clk);
      load = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (bcd !== 16'h9999) begin n_fail++; $display("FAIL pre_tick_bcd got=%h exp=9999", bcd); end
      // prescaler now at its terminal value: this edge would wrap without the load
      load = 1'b1; load_value = 16'h0042;
      @(negedge clk);
      load = 1'b0;
      n_checks++;
      if (bcd !== 16'h0042) begin n_fail++; $display("FAIL load_on_tick_bcd got=%h exp=0042", bcd); end
      n_checks++;
      if (wrap !== 1'b0) begin n_fail++; $display("FAIL load_on_tick_wrap got=%b exp=0", wrap); end
      enable = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         n_checks++;
         if (bcd !== 16'h0042 || wrap !== 1'b0) begin n_fail++; $display("FAIL hold_disabled k=%0d got=%h/%b exp=0042/0", k, bcd, wrap); end
      end
   endtask

   task automatic test_display();
      logic [15:0] vals [4];
      logic [31:0] exps [4];
      logic [7:0]  exp_seg;
      logic [3:0]  seen;
      int          pos;
      vals[0] = 16'h0042;
      vals[1] = 16'h0000;
      vals[2] = 16'h9876;
      vals[3] = 16'h1350;
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
      exps[0] = 32'hFFFF_99A4;
      exps[1] = 32'hFFFF_FFC0;
`else
      exps[0] = 32'hC0C0_99A4;
      exps[1] = 32'hC0C0_C0C0;
`endif
      exps[2] = 32'h9080_F882;
      exps[3] = 32'hF9B0_92C0;
      enable = 1'b0;
      for (int v = 0; v < 4; v++) begin
         load = 1'b1; load_value = vals[v];
         @(negedge clk);
         load = 1'b0;
         repeat (2) @(negedge clk);
         seen = '0;
         for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            case (anodes)
               4'hE:    pos = 0;
               4'hD:    pos = 1;
               4'hB:    pos = 2;
               4'h7:    pos = 3;
               default: pos = -1;
            endcase
            n_checks++;
            if (pos < 0) begin
               n_fail++; $display("FAIL display_anode_onehot val=%h got=%h exp=one-low", vals[v], anodes);
            end else begin
               seen[pos] = 1'b1;
               exp_seg   = exps[v][8*pos +: 8];
               n_checks++;
               if (segments !== exp_seg) begin n_fail++; $display("FAIL display_seg val=%h digit=%0d got=%h exp=%h", vals[v], pos, segments, exp_seg); end
            end
         end
         n_checks++;
         if (seen !== 4'hF) begin n_fail++; $display("FAIL display_scan_cover val=%h got=%h exp=f", vals[v], seen); end
      end
   endtask

   task automatic test_mid_reset();
      up_down = 1'b1; enable = 1'b1; load = 1'b1; load_value = 16'h0057;
      @(negedge clk);
      load = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (bcd !== 16'h0000) begin n_fail++; $display("FAIL mid_reset_bcd got=%h exp=0000", bcd); end
      n_checks++;
      if (anodes !== 4'hE) begin n_fail++; $display("FAIL mid_reset_anodes got=%h exp=e", anodes); end
      n_checks++;
      if (segments !== 8'hC0) begin n_fail++; $display("FAIL mid_reset_segments got=%h exp=c0", segments); end
      @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         n_checks++;
         if (bcd !== ((k == 4) ? 16'h0001 : 16'h0000)) begin n_fail++; $display("FAIL post_reset_period k=%0d got=%h exp=%0d", k, bcd, (k == 4) ? 1 : 0); end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_count_up();
      test_wrap_up();
      test_wrap_down();
      test_load_priority();
      test_display();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
